// File: rtl/gpr_scoreboard_if.sv
// Register-file bundle: read/write/issue requests toward the file, read data and scoreboard status back.
// Purely a signal grouping; no storage, no latency, no backpressure.
interface gpr_scoreboard_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] busa;
  logic [DW-1:0] busb;
  logic          busy_a;
  logic          busy_b;
  logic          we0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] wd0;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic          issue_en;
  logic [AW-1:0] issue_wr;
  logic          ovf_set;
  logic [AW:0]   pend_cnt;
  logic          wb_err;
  logic          issue_err;

  modport master (
    output ra, rb, we0, wa0, wd0, we1, wa1, wd1, issue_en, issue_wr, ovf_set,
    input  busa, busb, busy_a, busy_b, pend_cnt, wb_err, issue_err
  );

  modport slave (
    input  ra, rb, we0, wa0, wd0, we1, wa1, wd1, issue_en, issue_wr, ovf_set,
    output busa, busb, busy_a, busy_b, pend_cnt, wb_err, issue_err
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Dual-read/dual-write GPR file with busy scoreboard; reads are combinational (optionally bypassed),
// writes, busy, pend_cnt and error pulses update at the clock edge. Never stalls; issue logic stalls on busy.
module gpr_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int FLAG_REG = 30,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  gpr_scoreboard_if.slave io
);
  localparam int DEPTH = 1 << AW;
  localparam bit BYP   = (BYPASS != 0);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW:0]      pend_q;
  logic             wb_err_q;
  logic             issue_err_q;

  logic set_v;
  logic clr_v;
  logic same_reg;
  logic cnt_inc;
  logic cnt_dec;

  assign set_v    = io.issue_en && (io.issue_wr != '0);
  assign clr_v    = io.we1 && (io.wa1 != '0);
  assign same_reg = set_v && clr_v && (io.issue_wr == io.wa1);
  // A same-cycle re-issue keeps the register busy, so the clear does not count.
  assign cnt_inc  = set_v && !busy[io.issue_wr];
  assign cnt_dec  = clr_v && busy[io.wa1] && !same_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (io.ovf_set && (i == FLAG_REG))
          regs[i] <= DW'(1);
        else if (io.we0 && (io.wa0 == AW'(i)))
          regs[i] <= io.wd0;
        else if (io.we1 && (io.wa1 == AW'(i)))
          regs[i] <= io.wd1;
      end
    end
  end

  // Set is issued after clear so a re-issue to the retiring register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_v) busy[io.wa1]      <= 1'b0;
      if (set_v) busy[io.issue_wr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      wb_err_q    <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      pend_q      <= pend_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
      wb_err_q    <= clr_v && !busy[io.wa1];
      issue_err_q <= set_v && busy[io.issue_wr] && !(clr_v && (io.wa1 == io.issue_wr));
    end
  end

  function automatic logic [DW-1:0] read_port(
    input logic [AW-1:0] a,
    input logic [DW-1:0] stored,
    input logic          ovf,
    input logic          we0,
    input logic [AW-1:0] wa0,
    input logic [DW-1:0] wd0,
    input logic          we1,
    input logic [AW-1:0] wa1,
    input logic [DW-1:0] wd1
  );
    logic [DW-1:0] v;
    v = stored;
    if (a == '0)
      v = '0;
    else if (BYP) begin
      if (ovf && (a == AW'(FLAG_REG)))
        v = DW'(1);
      else if (we0 && (wa0 == a))
        v = wd0;
      else if (we1 && (wa1 == a))
        v = wd1;
    end
    return v;
  endfunction

  logic [DW-1:0] busa_c;
  logic [DW-1:0] busb_c;
  logic          busy_a_c;
  logic          busy_b_c;

  always_comb begin
    busa_c = read_port(io.ra, regs[io.ra], io.ovf_set, io.we0, io.wa0, io.wd0,
                       io.we1, io.wa1, io.wd1);
    busb_c = read_port(io.rb, regs[io.rb], io.ovf_set, io.we0, io.wa0, io.wd0,
                       io.we1, io.wa1, io.wd1);
  end

  // A retiring writeback releases the reader in the same cycle unless the register is re-issued.
  always_comb begin
    busy_a_c = busy[io.ra];
    busy_b_c = busy[io.rb];
    if (BYP && clr_v && (io.wa1 == io.ra) && !(set_v && (io.issue_wr == io.ra)))
      busy_a_c = 1'b0;
    if (BYP && clr_v && (io.wa1 == io.rb) && !(set_v && (io.issue_wr == io.rb)))
      busy_b_c = 1'b0;
  end

  assign io.busa      = busa_c;
  assign io.busb      = busb_c;
  assign io.busy_a    = busy_a_c;
  assign io.busy_b    = busy_b_c;
  assign io.pend_cnt  = pend_q;
  assign io.wb_err    = wb_err_q;
  assign io.issue_err = issue_err_q;
endmodule
